// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, program-loadable instruction memory and fetch queue
//
// Holds the fetch PC, issues one synchronous instruction-memory read per cycle
// while the queue has room, and buffers {pc, inst, fault} entries for decode.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   redirect_valid/_pc         branch/jump taken: flush queue, squash read, restart fetch
//   out_valid/out_ready        head-of-queue handshake towards decode
//   out_pc/out_inst/out_pc4    head entry fields (zero while the queue is empty)
//   out_fault                  head entry came from a misaligned or out-of-range PC
//   imem_we/_waddr/_wdata      program-load write port (read-first against fetch)
//   fetch_count                entries accepted by decode since reset, wraps

module instruction_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              ILEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter int              FQ_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [ILEN-1:0]               out_inst,
  output logic [XLEN-1:0]               out_pc4,
  output logic                          out_fault,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [ILEN-1:0]               imem_wdata,
  output logic [31:0]                   fetch_count
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int CW = QW + 1;
  localparam logic [ILEN-1:0] NOP       = ILEN'(32'h0000_0013);
  // One extra bit so the range limit is representable even for narrow XLEN.
  localparam logic [XLEN:0]   MEM_BYTES = (XLEN+1)'(4 * IMEM_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_q;
  logic            req_q;
  logic [ILEN-1:0] mem [IMEM_DEPTH];
  logic [ILEN-1:0] rdata;

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [ILEN-1:0] q_inst  [FQ_DEPTH];
  logic            q_fault [FQ_DEPTH];
  logic [QW-1:0]   wr_ptr;
  logic [QW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            deq;
  logic            issue;
  logic            push;
  logic            fault_q;
  logic [CW:0]     occupancy;

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;

  // Queued entries plus the read in flight, less the one leaving this cycle.
  // Issuing only below FQ_DEPTH is what makes overflow impossible.
  assign occupancy = {1'b0, count} + (CW+1)'(req_q) - (CW+1)'(deq);
  assign issue     = !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
  assign push      = req_q && !redirect_valid;
  assign fault_q   = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= MEM_BYTES);

  // Memory is not reset. Non-blocking read and write give read-first behaviour;
  // rdata is only consumed the cycle after an issue, when pc was the read address.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
    rdata <= mem[pc[2 +: AW]];
  end

  // Queue payload needs no reset: it is only visible while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc_q;
      q_inst[wr_ptr]  <= fault_q ? NOP : rdata;
      q_fault[wr_ptr] <= fault_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_q        <= '0;
      req_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // Flush wins over everything: queued entries, the in-flight read and any
      // simultaneous dequeue are all dropped.
      pc     <= redirect_pc;
      req_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc_q <= pc;
        pc   <= pc + XLEN'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + QW'(1);
      end
      if (deq) begin
        rd_ptr      <= rd_ptr + QW'(1);
        fetch_count <= fetch_count + 32'd1;
      end
      count <= count + CW'(push) - CW'(deq);
    end
  end

  always_comb begin
    out_pc    = '0;
    out_inst  = '0;
    out_pc4   = '0;
    out_fault = 1'b0;
    if (out_valid) begin
      out_pc    = q_pc[rd_ptr];
      out_inst  = q_inst[rd_ptr];
      out_pc4   = q_pc[rd_ptr] + XLEN'(4);
      out_fault = q_fault[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;

  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] out_pc4;
  logic        out_fault;
  logic [31:0] fetch_count;

  logic        redirect_valid32 = 1'b0;
  logic [31:0] redirect_pc32 = '0;
  logic        out_ready32 = 1'b0;
  logic        out_valid32;
  logic [31:0] out_pc32;
  logic [31:0] out_inst32;
  logic [31:0] out_pc4_32;
  logic        out_fault32;
  logic [31:0] fetch_count32;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb64[$];
  exp_t sb32[$];
  logic [31:0] mem_model [64];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pc4(out_pc4), .out_fault(out_fault),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid32), .redirect_pc(redirect_pc32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_pc(out_pc32), .out_inst(out_inst32), .out_pc4(out_pc4_32), .out_fault(out_fault32),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .fetch_count(fetch_count32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp64(input logic [63:0] pc, input logic flt);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 64'd4;
    e.fault = flt;
    e.inst  = flt ? 32'h0000_0013 : mem_model[pc[7:2]];
    sb64.push_back(e);
  endtask

  task automatic exp32(input logic [31:0] pc, input logic flt);
    exp_t e;
    logic [31:0] p4;
    p4      = pc + 32'd4;
    e.pc    = {32'h0, pc};
    e.pc4   = {32'h0, p4};
    e.fault = flt;
    e.inst  = flt ? 32'h0000_0013 : mem_model[pc[7:2]];
    sb32.push_back(e);
  endtask

  task automatic redirect64(input logic [63:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
  endtask

  // Raise ready until the scoreboard drains, then drop it; returns cycles used.
  task automatic deliver(input bit is32, output int n);
    n = 0;
    if (is32) out_ready32 = 1'b1; else out_ready = 1'b1;
    while (((is32 ? sb32.size() : sb64.size()) != 0) && n < 50) begin
      tick();
      n++;
    end
    out_ready32 = 1'b0;
    out_ready   = 1'b0;
    if ((is32 ? sb32.size() : sb64.size()) != 0) begin
      miscompares++;
      $display("FAIL deliver_timeout: %0d entries never delivered, expected 0", is32 ? sb32.size() : sb64.size());
      if (is32) sb32.delete(); else sb64.delete();
    end
  endtask

  // Monitors: a handshake that completes on a non-redirect edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      if (sb64.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected64: got pc %h, expected no delivery", out_pc);
      end else begin
        exp_t e;
        e = sb64.pop_front();
        check("pc64", out_pc, e.pc);
        check("inst64", {32'h0, out_inst}, {32'h0, e.inst});
        check("pc4_64", out_pc4, e.pc4);
        check("fault64", {63'h0, out_fault}, {63'h0, e.fault});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid32 && out_ready32 && !redirect_valid32) begin
      if (sb32.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected32: got pc %h, expected no delivery", out_pc32);
      end else begin
        exp_t e;
        e = sb32.pop_front();
        check("pc32", {32'h0, out_pc32}, e.pc);
        check("inst32", {32'h0, out_inst32}, {32'h0, e.inst});
        check("pc4_32", {32'h0, out_pc4_32}, e.pc4);
        check("fault32", {63'h0, out_fault32}, {63'h0, e.fault});
      end
    end
  end

  always @(negedge clk) begin
    assert (dut.count <= 2 && dut32.count <= 2)
    else begin
      miscompares++;
      $display("FAIL fq_bound: got count %0d/%0d, expected <= 2", dut.count, dut32.count);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);

    // Reset state and program load (memory is writable while in reset).
    tick();
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_count", {32'h0, fetch_count}, 64'h0);
    for (int i = 0; i < 64; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 6'(i);
      imem_wdata = mem_model[i];
      tick();
    end
    imem_we = 1'b0;

    // Streaming from reset: first valid after the second edge, then one per cycle.
    for (int i = 0; i < 10; i++) exp64(64'(4 * i), 1'b0);
    out_ready = 1'b1;
    reset     = 1'b0;
    tick();
    check("first_valid_e1", {63'h0, out_valid}, 64'h0);
    tick();
    check("first_valid_e2", {63'h0, out_valid}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      check("stream_gapless", {63'h0, out_valid}, 64'h1);
      tick();
    end
    out_ready = 1'b0;
    check("t1_count", {32'h0, fetch_count}, 64'd10);

    // Redirect with a coincident handshake: that dequeue is dropped and not counted.
    out_ready = 1'b1;
    redirect64(64'h0);
    check("redir_deq_dropped", {32'h0, fetch_count}, 64'd10);
    for (int i = 0; i < 4; i++) exp64(64'(4 * i), 1'b0);
    tick();
    check("redir_valid_e1", {63'h0, out_valid}, 64'h0);
    tick();
    check("redir_valid_e2", {63'h0, out_valid}, 64'h1);
    for (int k = 0; k < 5; k++) begin
      check("bp_head_pc", out_pc, 64'h0);
      check("bp_head_valid", {63'h0, out_valid}, 64'h1);
      tick();
    end
    deliver(1'b0, n);
    check("bp_release_cycles", 64'(n), 64'd4);
    check("bp_count", {32'h0, fetch_count}, 64'd14);

    // Flush with one entry queued and a read in flight.
    check("pre_flush_head", out_pc, 64'h10);
    redirect64(64'h20);
    exp64(64'h20, 1'b0);
    exp64(64'h24, 1'b0);
    tick();
    check("flush_valid_e1", {63'h0, out_valid}, 64'h0);
    tick();
    check("flush_valid_e2", {63'h0, out_valid}, 64'h1);
    deliver(1'b0, n);
    check("flush_count", {32'h0, fetch_count}, 64'd16);

    // Faulting fetches: misaligned, last in-range word, then past the end.
    redirect64(64'h22);
    exp64(64'h22, 1'b1);
    exp64(64'h26, 1'b1);
    deliver(1'b0, n);
    redirect64(64'hFC);
    exp64(64'hFC, 1'b0);
    exp64(64'h100, 1'b1);
    exp64(64'h104, 1'b1);
    exp64(64'h108, 1'b1);
    deliver(1'b0, n);
    check("fault_count", {32'h0, fetch_count}, 64'd22);

    // Write to the word being read on the issue edge returns the old data.
    redirect64(64'h40);
    imem_we    = 1'b1;
    imem_waddr = 6'd16;
    imem_wdata = 32'h1234_5678;
    exp64(64'h40, 1'b0);
    exp64(64'h44, 1'b0);
    tick();
    imem_we = 1'b0;
    mem_model[16] = 32'h1234_5678;
    deliver(1'b0, n);
    redirect64(64'h40);
    exp64(64'h40, 1'b0);
    deliver(1'b0, n);
    check("rf_count", {32'h0, fetch_count}, 64'd25);

    // Asynchronous reset with a valid head and a read in flight.
    redirect64(64'h0);
    tick();
    tick();
    check("pre_reset_valid", {63'h0, out_valid}, 64'h1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {63'h0, out_valid}, 64'h0);
    check("async_rst_count", {32'h0, fetch_count}, 64'h0);
    check("async_rst_pc", out_pc, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    exp64(64'h0, 1'b0);
    exp64(64'h4, 1'b0);
    exp64(64'h8, 1'b0);
    deliver(1'b0, n);
    check("post_rst_count", {32'h0, fetch_count}, 64'd3);

    // 32-bit PC wrap: faulting entry at the top, then fetch continues from 0.
    redirect_pc32    = 32'hFFFF_FFFC;
    redirect_valid32 = 1'b1;
    tick();
    redirect_valid32 = 1'b0;
    exp32(32'hFFFF_FFFC, 1'b1);
    exp32(32'h0, 1'b0);
    exp32(32'h4, 1'b0);
    deliver(1'b1, n);
    check("wrap_count32", {32'h0, fetch_count32}, 64'd3);

    check("sb64_empty", 64'(sb64.size()), 64'h0);
    check("sb32_empty", 64'(sb32.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
